// File: rtl/bsg_credit_packet_arbiter.sv
// ---------------------------------------------------------------------------
// bsg_credit_packet_arbiter
//
// Round-robin arbiter sharing one credit-flow-controlled link among
// num_req_p requesters. Packets are multi-flit and never interleave: once a
// requester's first flit is accepted the link stays locked to it until its
// last flit is accepted. One credit is spent per accepted flit.
//
// Optional feature (macro BSG_CREDIT_ARB_STALL_CNT_EN):
//   defined   -> saturating credit-stall cycle counter is built
//   undefined -> no counter flops, stall_cycles_o tied to 0,
//                stall_clear_i ignored
//
// Ports:
//   clk_i            clock (credit-spending domain)
//   reset_i          synchronous active-high reset
//   v_i              per-requester flit valid
//   last_i           per-requester "offered flit ends its packet"
//   yumi_o           one-hot, flit of that requester accepted this cycle
//   grant_o          one-hot current link owner, or 0
//   locked_o         mid-packet lock held
//   credits_avail_i  credit counter has credits
//   dec_credit_o     credit-decrement strobe (= |yumi_o)
//   stall_clear_i    clears the stall counter
//   stall_cycles_o   saturating credit-stall cycle count
// ---------------------------------------------------------------------------
module bsg_credit_packet_arbiter #(
  parameter int num_req_p         = 4,
  parameter int stall_cnt_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p-1:0]         v_i,
  input  logic [num_req_p-1:0]         last_i,
  output logic [num_req_p-1:0]         yumi_o,
  output logic [num_req_p-1:0]         grant_o,
  output logic                         locked_o,
  input  logic                         credits_avail_i,
  output logic                         dec_credit_o,
  input  logic                         stall_clear_i,
  output logic [stall_cnt_width_p-1:0] stall_cycles_o
);

  localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  typedef logic [idx_w_lp-1:0] idx_t;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_r, state_n;
  idx_t                 owner_r, owner_n;
  idx_t                 rr_ptr_r, rr_ptr_n;
  idx_t                 pick_idx, scan_idx, win_idx;
  logic                 pick_found, win_any;
  logic [num_req_p-1:0] win_oh;
  logic                 accept;
  logic                 stall_cond;

  function automatic idx_t wrap_inc(input idx_t i);
    if (int'(i) == num_req_p - 1) return '0;
    return idx_t'(int'(i) + 1);
  endfunction

  // Round-robin pick: first valid requester scanning from rr_ptr_r upward.
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      scan_idx = idx_t'((int'(rr_ptr_r) + k) % num_req_p);
      if (!pick_found && v_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // While locked the owner keeps the grant regardless of its valid.
  assign win_idx = (state_r == LOCKED) ? owner_r : pick_idx;
  assign win_any = (state_r == LOCKED) | pick_found;

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  assign grant_o      = (reset_i || !win_any) ? '0 : win_oh;
  assign yumi_o       = grant_o & v_i & {num_req_p{credits_avail_i}};
  assign accept       = |yumi_o;
  assign dec_credit_o = accept;
  assign locked_o     = !reset_i && (state_r == LOCKED);
  assign stall_cond   = (|(grant_o & v_i)) & ~credits_avail_i;

  // last_i only steers next state; it never reaches an output directly.
  always_comb begin
    state_n  = state_r;
    owner_n  = owner_r;
    rr_ptr_n = rr_ptr_r;
    if (accept) begin
      if (last_i[win_idx]) begin
        state_n  = IDLE;
        rr_ptr_n = wrap_inc(win_idx);
      end else begin
        state_n  = LOCKED;
        owner_n  = win_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      rr_ptr_r <= rr_ptr_n;
    end
  end

`ifdef BSG_CREDIT_ARB_STALL_CNT_EN
  logic [stall_cnt_width_p-1:0] stall_cnt_r;

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (reset_i || stall_clear_i) begin
      stall_cnt_r <= '0;
    end else if (stall_cond && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt_r;
`else
  logic unused_stall_sigs;
  assign unused_stall_sigs = stall_clear_i | stall_cond;
  assign stall_cycles_o    = '0;
`endif

endmodule
